corner_dispatch_ctrl: RTL

Parametrised dispatcher between the corner detector and a bank of NUM_GEN ORB descriptor generators. On each corner strobe it grants the lowest-index idle generator and records the grant order in an internal order queue. It steers the incoming sample stream to the oldest outstanding generator, advancing to the next one after exactly SAMPLES samples. It also reports occupancy and counts dropped corners and orphan samples.

---
 rtl/corner_dispatch_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/corner_dispatch_ctrl.sv
// corner_dispatch_ctrl: grants idle ORB descriptor generators on corner strobes,
// keeps the grant order in a circular queue and steers the sample stream to
// the oldest outstanding generator, SAMPLES samples per corner.
module corner_dispatch_ctrl #(
  parameter int unsigned NUM_GEN = 4,
  parameter int unsigned SAMPLES = 256,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             is_corner,
  input  logic                             sample_valid,
  input  logic [NUM_GEN-1:0]               is_working,
  output logic [NUM_GEN-1:0]               ena,
  output logic [NUM_GEN-1:0]               sample_valid_o,
  output logic                             is_full,
  output logic [$clog2(NUM_GEN+1)-1:0]     occupancy,
  output logic [$clog2(NUM_GEN)-1:0]       head_idx,
  output logic [CNT_W-1:0]                 corner_drop_cnt,
  output logic [CNT_W-1:0]                 sample_orphan_cnt
);

  localparam int unsigned IDX_W  = $clog2(NUM_GEN);
  localparam int unsigned OCC_W  = $clog2(NUM_GEN + 1);
  localparam int unsigned SCNT_W = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SAMPLES - 1);
  localparam logic [NUM_GEN-1:0] ONE_HOT0 = NUM_GEN'(1);

  logic [IDX_W-1:0]   queue [NUM_GEN];
  logic [IDX_W-1:0]   rd_ptr;
  logic [IDX_W-1:0]   wr_ptr;
  logic [OCC_W-1:0]   occ;
  logic [NUM_GEN-1:0] in_flight;
  logic [SCNT_W-1:0]  scnt;

  logic [NUM_GEN-1:0] busy;
  logic               all_busy;
  logic [NUM_GEN-1:0] grant_vec;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_found;
  logic               push;
  logic               routed;
  logic               pop;
  logic               orphan;
  logic               drop;
  logic [NUM_GEN-1:0] head_mask;

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    if (p == IDX_W'(NUM_GEN - 1)) return '0;
    else return p + IDX_W'(1);
  endfunction

  assign busy      = is_working | in_flight;
  assign all_busy  = &busy;
  assign head_idx  = queue[rd_ptr];
  assign head_mask = ONE_HOT0 << head_idx;
  assign occupancy = occ;

  // Lowest-index idle generator
  always_comb begin
    grant_vec   = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int unsigned i = 0; i < NUM_GEN; i++) begin
      if (!busy[i] && !grant_found) begin
        grant_vec[i] = 1'b1;
        grant_idx    = IDX_W'(i);
        grant_found  = 1'b1;
      end
    end
  end

  // Combinational strobes, gated off while reset is asserted
  always_comb begin
    push           = rst_n && is_corner && grant_found;
    drop           = rst_n && is_corner && all_busy;
    routed         = rst_n && sample_valid && (occ != '0);
    orphan         = rst_n && sample_valid && (occ == '0);
    pop            = routed && (scnt == SCNT_LAST);
    ena            = push ? grant_vec : '0;
    sample_valid_o = routed ? head_mask : '0;
    is_full        = rst_n && all_busy;
  end

  // Order queue, pointers, occupancy, in-flight mask and sample counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_GEN; i++) queue[i] <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occ       <= '0;
      in_flight <= '0;
      scnt      <= '0;
    end else begin
      if (push) begin
        queue[wr_ptr] <= grant_idx;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
      // grant and pop never target the same generator, so set/clear do not collide
      in_flight <= (in_flight | ena) & ~(pop ? head_mask : '0);
      if (routed) scnt <= pop ? '0 : scnt + SCNT_W'(1);
    end
  end

  // Saturating drop and orphan counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      corner_drop_cnt   <= '0;
      sample_orphan_cnt <= '0;
    end else begin
      if (drop && (corner_drop_cnt != '1))
        corner_drop_cnt <= corner_drop_cnt + CNT_W'(1);
      if (orphan && (sample_orphan_cnt != '1))
        sample_orphan_cnt <= sample_orphan_cnt + CNT_W'(1);
    end
  end

endmodule
